// File: rtl/branch_predictor_if.sv
// -----------------------------------------------------------------------------
// branch_predictor_if
// Purpose : Bundles the fetch-side lookup, the execute-side training/update
//           channel and the redirect/statistics outputs of branch_predictor.
//           Signal suffixes (_i/_o) are written from the predictor's point of view.
// Modports:
//   master - fetch/execute pipeline side: drives the lookup PC and the update
//            channel, observes prediction, redirect and statistics.
//   slave  - the predictor itself.
// Signals :
//   fetch_pc_i        PC being fetched
//   pred_taken_o      predicted direction for fetch_pc_i
//   pred_target_o     predicted next PC for fetch_pc_i
//   upd_valid_i       a conditional branch resolved this cycle
//   upd_pc_i          PC of the resolved branch
//   upd_target_i      computed branch target
//   upd_taken_i       actual outcome
//   upd_pred_taken_i  prediction carried down the pipe
//   upd_pred_target_i predicted target carried down the pipe
//   mispredict_o      registered one-cycle mispredict pulse
//   redirect_pc_o     registered correct next PC
//   br_cnt_o          saturating resolved-branch count
//   mispred_cnt_o     saturating mispredict count
// -----------------------------------------------------------------------------
interface branch_predictor_if #(
    parameter int DW = 32
);
    logic [DW-1:0] fetch_pc_i;
    logic          pred_taken_o;
    logic [DW-1:0] pred_target_o;
    logic          upd_valid_i;
    logic [DW-1:0] upd_pc_i;
    logic [DW-1:0] upd_target_i;
    logic          upd_taken_i;
    logic          upd_pred_taken_i;
    logic [DW-1:0] upd_pred_target_i;
    logic          mispredict_o;
    logic [DW-1:0] redirect_pc_o;
    logic [31:0]   br_cnt_o;
    logic [31:0]   mispred_cnt_o;

    modport master (
        output fetch_pc_i, upd_valid_i, upd_pc_i, upd_target_i,
               upd_taken_i, upd_pred_taken_i, upd_pred_target_i,
        input  pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o,
               br_cnt_o, mispred_cnt_o
    );

    modport slave (
        input  fetch_pc_i, upd_valid_i, upd_pc_i, upd_target_i,
               upd_taken_i, upd_pred_taken_i, upd_pred_target_i,
        output pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o,
               br_cnt_o, mispred_cnt_o
    );
endinterface

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Purpose : Direct-mapped 2-bit saturating-counter predictor with a branch
//           target buffer. Combinational lookup for the fetch PC, training
//           from the resolved execute-stage outcome, registered mispredict /
//           redirect to the PC logic and saturating statistics counters.
// Ports   :
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-high reset; clears table, redirect, counters
//   bp     - branch_predictor_if.slave (lookup, update, redirect, stats)
// Parameters:
//   DW     - data/address width (must match the interface)
//   IDX_W  - table index width, 2^IDX_W entries
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int DW    = 32,
    parameter int IDX_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    branch_predictor_if.slave bp
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = DW - IDX_W - 2;
    localparam logic [DW-1:0] PC_STEP = {{(DW-3){1'b0}}, 3'b100};

    // Saturating 2-bit counter step: up on taken, down on not-taken.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        case ({taken, ctr})
            3'b100:  nxt = 2'b01;
            3'b101:  nxt = 2'b10;
            3'b110:  nxt = 2'b11;
            3'b111:  nxt = 2'b11;
            3'b000:  nxt = 2'b00;
            3'b001:  nxt = 2'b00;
            3'b010:  nxt = 2'b01;
            3'b011:  nxt = 2'b10;
            default: nxt = 2'b01;
        endcase
        return nxt;
    endfunction

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [DW-1:0]    r_target [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];

    logic          r_mispredict;
    logic [DW-1:0] r_redirect_pc;
    logic [31:0]   r_br_cnt;
    logic [31:0]   r_mispred_cnt;

    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic             w_f_hit;
    logic             w_pred_taken;
    logic [DW-1:0]    w_pred_target;
    logic [IDX_W-1:0] w_u_idx;
    logic [TAG_W-1:0] w_u_tag;
    logic             w_u_hit;
    logic             w_mispredict;
    logic [DW-1:0]    w_redirect_pc;
    logic             w_unused_bits;

    assign w_f_idx = bp.fetch_pc_i[IDX_W+1:2];
    assign w_f_tag = bp.fetch_pc_i[DW-1:IDX_W+2];
    assign w_u_idx = bp.upd_pc_i[IDX_W+1:2];
    assign w_u_tag = bp.upd_pc_i[DW-1:IDX_W+2];
    // Byte-offset bits of the PCs carry no branch identity.
    assign w_unused_bits = ^{bp.fetch_pc_i[1:0], bp.upd_pc_i[1:0]};

    // Fetch lookup: reads the current table state, so a same-cycle update is not seen.
    always_comb begin
        w_f_hit       = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
        w_pred_taken  = w_f_hit && r_ctr[w_f_idx][1];
        w_pred_target = bp.fetch_pc_i + PC_STEP;
        if (w_pred_taken) begin
            w_pred_target = r_target[w_f_idx];
        end else begin
            w_pred_target = bp.fetch_pc_i + PC_STEP;
        end
    end

    // Update-side hit detection, mispredict condition and correct next PC.
    always_comb begin
        w_u_hit       = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
        w_mispredict  = (bp.upd_taken_i != bp.upd_pred_taken_i) ||
                        (bp.upd_taken_i && bp.upd_pred_taken_i &&
                         (bp.upd_target_i != bp.upd_pred_target_i));
        w_redirect_pc = bp.upd_pc_i + PC_STEP;
        if (bp.upd_taken_i) begin
            w_redirect_pc = bp.upd_target_i;
        end else begin
            w_redirect_pc = bp.upd_pc_i + PC_STEP;
        end
    end

    // Predictor table training; reset clears every entry to invalid / weak-NT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (bp.upd_valid_i) begin
            if (w_u_hit) begin
                r_ctr[w_u_idx] <= ctr_step(r_ctr[w_u_idx], bp.upd_taken_i);
                if (bp.upd_taken_i) begin
                    r_target[w_u_idx] <= bp.upd_target_i;
                end
            end else if (bp.upd_taken_i) begin
                // Taken miss evicts whatever alias lived at this index.
                r_valid[w_u_idx]  <= 1'b1;
                r_tag[w_u_idx]    <= w_u_tag;
                r_target[w_u_idx] <= bp.upd_target_i;
                r_ctr[w_u_idx]    <= 2'b10;
            end else begin
                r_valid[w_u_idx] <= r_valid[w_u_idx];
            end
        end else begin
            r_valid[w_u_idx] <= r_valid[w_u_idx];
        end
    end

    // Redirect pulse and saturating statistics.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mispredict  <= 1'b0;
            r_redirect_pc <= '0;
            r_br_cnt      <= 32'd0;
            r_mispred_cnt <= 32'd0;
        end else begin
            r_mispredict <= bp.upd_valid_i && w_mispredict;
            // Redirect PC only moves on a real mispredict and otherwise holds.
            if (bp.upd_valid_i && w_mispredict) begin
                r_redirect_pc <= w_redirect_pc;
                if (r_mispred_cnt != 32'hFFFF_FFFF) begin
                    r_mispred_cnt <= r_mispred_cnt + 32'd1;
                end
            end
            if (bp.upd_valid_i && (r_br_cnt != 32'hFFFF_FFFF)) begin
                r_br_cnt <= r_br_cnt + 32'd1;
            end
        end
    end

    assign bp.pred_taken_o  = w_pred_taken;
    assign bp.pred_target_o = w_pred_target;
    assign bp.mispredict_o  = r_mispredict;
    assign bp.redirect_pc_o = r_redirect_pc;
    assign bp.br_cnt_o      = r_br_cnt;
    assign bp.mispred_cnt_o = r_mispred_cnt;
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the RISC-V CPU fetch stage and the consumer of the execute-stage branch decision. It predicts taken/not-taken and the target for the PC being fetched, using a direct-mapped table of 2-bit saturating counters with a branch target buffer. It is trained by the resolved outcome from the branch comparator (`branch_o`) one pipeline stage later. It also raises a registered mispredict/redirect to the PC logic and keeps branch and mispredict statistics.

## Interface
- `DW`, 32, data/address width
- `IDX_W`, 6, table index width (2^IDX_W entries, 64 by default)
- `clk_i`  in  1  clock, rising edge
- `rst_i`  in  1  reset; asynchronous, active-high
- `fetch_pc_i`  in  DW  PC currently being fetched
- `pred_taken_o`  out  1  prediction for `fetch_pc_i` (combinational from table state)
- `pred_target_o`  out  DW  predicted next PC for `fetch_pc_i`
- `upd_valid_i`  in  1  a conditional branch resolved in execute this cycle
- `upd_pc_i`  in  DW  PC of the resolved branch
- `upd_target_i`  in  DW  computed branch target (PC + B-immediate)
- `upd_taken_i`  in  1  actual outcome (comparator `branch_o`)
- `upd_pred_taken_i`  in  1  prediction that was made for this branch, carried down the pipe
- `upd_pred_target_i`  in  DW  predicted target carried down the pipe
- `mispredict_o`  out  1  registered; one-cycle pulse on a misprediction
- `redirect_pc_o`  out  DW  registered; correct next PC, valid while `mispredict_o`=1
- `br_cnt_o`  out  32  resolved-branch count, saturating
- `mispred_cnt_o`  out  32  misprediction count, saturating

## Operation
- Entry fields: `valid`, `tag` (DW-IDX_W-2 bits), `target` (DW), `ctr` (2 bits). The table is held in flops so reset can clear it.
- Address split:
  - index = `pc[IDX_W+1:2]`
  - tag = `pc[DW-1:IDX_W+2]`
  - `pc[1:0]` is ignored.
- Lookup (combinational):
  - hit = `valid` && tag match at the `fetch_pc_i` index.
  - `pred_taken_o` = hit && `ctr[1]`.
  - `pred_target_o` = entry `target` when `pred_taken_o`=1, else `fetch_pc_i`+4 (mod 2^DW).
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Update, on a clock edge where `upd_valid_i`=1:
  - Hit at the `upd_pc_i` index: `ctr` increments if taken, decrements if not, saturating at 11/00. If taken, `target` is overwritten with `upd_target_i`.
  - Miss and taken: allocate the entry (overwrite any other tag). Set `valid`=1, tag, `target`=`upd_target_i`, `ctr`=10.
  - Miss and not taken: the table is unchanged.
- Mispredict condition:
  - `upd_taken_i` != `upd_pred_taken_i`, or
  - `upd_taken_i` && `upd_pred_taken_i` && `upd_target_i` != `upd_pred_target_i`.
- Redirect value: `upd_taken_i` ? `upd_target_i` : `upd_pc_i`+4.
- Statistics:
  - `br_cnt_o` increments on every `upd_valid_i`.
  - `mispred_cnt_o` increments on every mispredict.
  - Both hold at 0xFFFFFFFF once reached.
- Only conditional branches update the predictor. JAL/JALR never assert `upd_valid_i`; that is the caller's responsibility.

## Timing
- Reset (asynchronous, takes effect immediately while `rst_i`=1):
  - All entries: `valid`=0, `ctr`=01, tag=0, target=0.
  - `mispredict_o`=0, `redirect_pc_o`=0, both counters=0.
  - So `pred_taken_o`=0 and `pred_target_o`=`fetch_pc_i`+4.
- Lookup latency is 0 cycles. Update is visible to lookup from the cycle after the `upd_valid_i` edge.
- Same-cycle read/write of one index: lookup returns the pre-update state; there is no bypass.
- `mispredict_o`/`redirect_pc_o` register on the edge that samples `upd_valid_i`. They are valid for exactly the following cycle, then `mispredict_o` returns to 0; `redirect_pc_o` holds its last value.
- Back-to-back updates (one per cycle) are fully supported. Consecutive mispredicts give consecutive one-cycle pulses, each carrying its own redirect PC.
- Reset asserted mid-stream: any pending mispredict is dropped, and no update is applied on an edge where `rst_i`=1.

## Test plan
- Reset, then `fetch_pc_i`=0x100 -> `pred_taken_o`=0, `pred_target_o`=0x104, all counters 0.
- Update pc=0x100, target=0x80, taken=1, pred_taken=0 -> next cycle `mispredict_o`=1, `redirect_pc_o`=0x80. Afterwards fetch 0x100 gives `pred_taken_o`=1, target 0x80, and counts are `br_cnt_o`=1, `mispred_cnt_o`=1.
- Same branch not-taken twice (pred_taken=1 then 0) -> `ctr` goes 10→01→00. First update mispredicts with redirect 0x104; second does not; fetch 0x100 predicts 0.
- Aliasing: allocate 0x100 taken, then update 0x200 (same index, IDX_W=6) taken with target 0x40 -> fetch 0x100 misses and predicts 0x104; fetch 0x200 predicts 0x40.
- Same-cycle fetch and update of 0x100 on an empty table -> that cycle `pred_taken_o`=0; next cycle `pred_taken_o`=1.
- Target mismatch: taken, pred_taken=1, pred_target 0x80, actual 0x90 -> mispredict with redirect 0x90. Then assert `rst_i` mid-cycle -> outputs clear immediately and the table is empty.
